m16_word_serializer: RTL and testbench

Serializes 16-bit telemetry words into a bit stream paced by a divided clock from the upstream clock divider (typically its divide-by-16 output). The block runs entirely on `iClkIN`, detects rising edges of the divided signal as bit ticks, and shifts words out MSB-first with an optional parity bit. A one-word holding buffer with a valid/ready handshake lets the next word load while the current one shifts, so back-to-back words stream without gaps.

---
 rtl/m16_ser_pkg.sv | 24 ++
 rtl/div_edge_det.sv | 36 +++
 rtl/m16_word_serializer.sv | 178 +++++++++++++++++
 tb/tb_m16_word_serializer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m16_ser_pkg.sv
// m16_ser_pkg
//   Shared definitions for the m16 word serializer:
//   - ser_state_e : serializer FSM states (IDLE, SHIFT, PARITY)
//   - DEF_WORD_W  : default data bits per word
//   - even_parity : parity bit that makes the total count of ones even
package m16_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  localparam int DEF_WORD_W = 16;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int MAX_WORD_W = 64;

  function automatic logic even_parity(input logic [MAX_WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// div_edge_det
//   Turns the divided clock from the clock divider into a one-cycle tick on
//   each of its rising edges. The divided clock is synchronous to iClkIN, so
//   it is registered once and compared, with no synchronizer.
//   Ports:
//     iClkIN  - system clock
//     reset   - asynchronous, active-low
//     iDivClk - divided clock level
//     oTick   - high for the one iClkIN cycle in which iDivClk has just risen
module div_edge_det (
  input  logic iClkIN,
  input  logic reset,
  input  logic iDivClk,
  output logic oTick
);

  logic d_div_q;
  // Set once iDivClk has been seen low after reset, so a divided clock that
  // is already high when reset releases does not look like a rising edge.
  logic armed_q;

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      d_div_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_div_q <= iDivClk;
      if (!iDivClk) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign oTick = iDivClk & ~d_div_q & armed_q;

endmodule

// File: rtl/m16_word_serializer.sv
// m16_word_serializer
//   Shifts WORD_W-bit words out MSB-first, one bit per rising edge of the
//   divided clock, optionally followed by an even-parity bit. A one-word
//   holding buffer (valid/ready) lets the next word be queued while the
//   current one shifts, so consecutive words stream with no idle bit.
//   Parameters:
//     WORD_W     - data bits per word (2..64)
//     PARITY_EN  - 1: append an even-parity bit to every word
//     IDLE_LEVEL - oSerData level while nothing is being sent
//   Ports:
//     iClkIN     - system clock, all logic on its rising edge
//     reset      - asynchronous, active-low
//     iDivClk    - divided clock, its rising edges pace the bits
//     iData      - word to send, captured when iValid & oReady
//     iValid     - iData is valid
//     oReady     - holding buffer empty
//     oSerData   - serial data
//     oBitStb    - one-cycle pulse whenever oSerData takes a new bit
//     oWordStart - one-cycle pulse with oBitStb on the MSB of each word
//     oBusy      - a word or its parity bit is on the line
//     oUnderrun  - one-cycle pulse when a word ends with the buffer empty
module m16_word_serializer
  import m16_ser_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              iClkIN,
  input  logic              reset,
  input  logic              iDivClk,
  input  logic [WORD_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic              oSerData,
  output logic              oBitStb,
  output logic              oWordStart,
  output logic              oBusy,
  output logic              oUnderrun
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic tick;

  div_edge_det u_div_edge_det (
    .iClkIN (iClkIN),
    .reset  (reset),
    .iDivClk(iDivClk),
    .oTick  (tick)
  );

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] buf_data_q, buf_data_d;
  logic              buf_full_q, buf_full_d;
  logic              ready_q;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              ser_q, ser_d;
  logic              bit_stb_q, bit_stb_d;
  logic              word_start_q, word_start_d;
  logic              underrun_q, underrun_d;
  logic              end_of_word;
  logic              load_word;

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      buf_data_q   <= '0;
      buf_full_q   <= 1'b0;
      ready_q      <= 1'b1;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      ser_q        <= IDLE_LEVEL;
      bit_stb_q    <= 1'b0;
      word_start_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_data_q   <= buf_data_d;
      buf_full_q   <= buf_full_d;
      // Registered copy of the buffer-empty flag; tracks buf_full_q exactly.
      ready_q      <= ~buf_full_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      parity_q     <= parity_d;
      ser_q        <= ser_d;
      bit_stb_q    <= bit_stb_d;
      word_start_q <= word_start_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_data_d   = buf_data_q;
    buf_full_d   = buf_full_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    parity_d     = parity_q;
    ser_d        = ser_q;
    bit_stb_d    = 1'b0;
    word_start_d = 1'b0;
    underrun_d   = 1'b0;
    end_of_word  = 1'b0;
    load_word    = 1'b0;

    // Accept and load are mutually exclusive: accept needs the buffer empty,
    // load needs it full. A word accepted on a tick therefore waits for the
    // following tick.
    if (iValid && ready_q) begin
      buf_data_d = iData;
      buf_full_d = 1'b1;
    end

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          load_word = buf_full_q;
        end
        ST_SHIFT: begin
          if (bit_cnt_q != '0) begin
            sh_d      = sh_q << 1;
            ser_d     = sh_q[WORD_W-2];
            bit_stb_d = 1'b1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else if (PARITY_EN) begin
            ser_d     = parity_q;
            bit_stb_d = 1'b1;
            state_d   = ST_PARITY;
          end else begin
            end_of_word = 1'b1;
          end
        end
        ST_PARITY: begin
          end_of_word = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (end_of_word) begin
        if (buf_full_q) begin
          load_word = 1'b1;
        end else begin
          ser_d      = IDLE_LEVEL;
          underrun_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      // Parity is taken from the word being loaded, so a later buffer write
      // cannot affect the parity bit of the word on the line.
      if (load_word) begin
        sh_d         = buf_data_q;
        ser_d        = buf_data_q[WORD_W-1];
        parity_d     = even_parity(MAX_WORD_W'(buf_data_q));
        bit_cnt_d    = LAST_BIT;
        buf_full_d   = 1'b0;
        bit_stb_d    = 1'b1;
        word_start_d = 1'b1;
        state_d      = ST_SHIFT;
      end
    end
  end

  assign oReady     = ready_q;
  assign oSerData   = ser_q;
  assign oBitStb    = bit_stb_q;
  assign oWordStart = word_start_q;
  assign oBusy      = (state_q != ST_IDLE);
  assign oUnderrun  = underrun_q;

endmodule

// File: tb/tb_m16_word_serializer.sv
module tb_m16_word_serializer;

  localparam int W = 16;

  logic         iClkIN  = 1'b0;
  logic         reset   = 1'b0;
  logic         iDivClk = 1'b0;
  logic         iValid  = 1'b0;
  logic [W-1:0] iData   = '0;
  logic         oReady, oSerData, oBitStb, oWordStart, oBusy, oUnderrun;

  m16_word_serializer #(.WORD_W(W), .PARITY_EN(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .iClkIN    (iClkIN),
    .reset     (reset),
    .iDivClk   (iDivClk),
    .iData     (iData),
    .iValid    (iValid),
    .oReady    (oReady),
    .oSerData  (oSerData),
    .oBitStb   (oBitStb),
    .oWordStart(oWordStart),
    .oBusy     (oBusy),
    .oUnderrun (oUnderrun)
  );

  always #5 iClkIN = ~iClkIN;

  // Divide-by-16 divided clock, updated on the falling edge of iClkIN.
  logic div_en  = 1'b1;
  int   div_cnt = 0;
  initial begin
    forever begin
      @(negedge iClkIN);
      if (div_en) begin
        div_cnt = (div_cnt + 1) % 16;
        iDivClk = (div_cnt >= 8);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word becomes WORD_W bits MSB-first plus
  // its even-parity bit; bits must appear in acceptance order.
  typedef struct packed {
    logic b;
    logic ws;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  logic     rx_q[$];
  int       stb_cyc_q[$];
  int       cyc     = 0;
  int       stb_cnt = 0;
  int       ws_cnt  = 0;
  int       ur_cnt  = 0;
  logic     div_prev = 1'b0;

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back('{b: w[i], ws: (i == W - 1)});
    end
    exp_q.push_back('{b: ^w, ws: 1'b0});
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge iClkIN) begin
    exp_bit_t e;
    #1;
    cyc++;
    if (oBitStb) begin
      stb_cnt++;
      stb_cyc_q.push_back(cyc);
      rx_q.push_back(oSerData);
      if (oWordStart) ws_cnt++;
      check("stb_on_tick", iDivClk & ~div_prev, 1'b1);
      check("bit_pending", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ser_bit", oSerData, e.b);
        check("word_start_flag", oWordStart, e.ws);
      end
    end else if (oWordStart) begin
      check("ws_needs_stb", oBitStb, 1'b1);
    end
    if (oUnderrun) begin
      ur_cnt++;
      check("underrun_no_stb", oBitStb, 1'b0);
      check("underrun_on_tick", iDivClk & ~div_prev, 1'b1);
    end
    div_prev = iDivClk;
  end

  task automatic step();
    @(posedge iClkIN);
    #2;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    logic rdy;
    bit   done;
    done   = 1'b0;
    iData  = w;
    iValid = 1'b1;
    for (int k = 0; k < 2000 && !done; k++) begin
      rdy = oReady;
      step();
      if (rdy) done = 1'b1;
    end
    iValid = 1'b0;
    check("accept_timeout", done, 1'b1);
    if (done) begin
      push_word(w);
      $display("tx word %h accepted at cycle %0d", w, cyc);
    end
  endtask

  task automatic wait_underrun(input int limit);
    int u0;
    int n;
    u0 = ur_cnt;
    n  = 0;
    while (ur_cnt == u0 && n < limit) begin
      step();
      n++;
    end
    check("underrun_timeout", (ur_cnt != u0), 1'b1);
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         par;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] got;
  logic [W-1:0] rw;
  logic         prev_rdy;
  bit           found;
  int           bad, n, s0, w0, u0;

  initial begin
    vecs = '{'{16'hA5C3, 1'b0}, '{16'h1234, 1'b1}, '{16'hFFFF, 1'b0},
             '{16'h0001, 1'b1}, '{16'h8000, 1'b1}, '{16'h7FFF, 1'b1}};

    // Reset values
    repeat (3) step();
    check("reset_ser", oSerData, 1'b0);
    check("reset_ready", oReady, 1'b1);
    check("reset_stb", oBitStb, 1'b0);
    check("reset_ws", oWordStart, 1'b0);
    check("reset_busy", oBusy, 1'b0);
    check("reset_underrun", oUnderrun, 1'b0);
    reset = 1'b1;

    // Divided clock running, no data: line stays quiet
    bad = 0;
    repeat (64) begin
      step();
      if (oSerData !== 1'b0 || oBusy !== 1'b0 || oBitStb !== 1'b0 ||
          oUnderrun !== 1'b0 || oReady !== 1'b1) bad++;
    end
    check("idle_quiet", bad, 0);

    // Table of single words: bits, parity, pulses, spacing
    for (int v = 0; v < 6; v++) begin
      rx_q.delete();
      stb_cyc_q.delete();
      w0 = ws_cnt;
      u0 = ur_cnt;
      send_word(vecs[v].word);
      wait_underrun(600);
      check("vec_nbits", rx_q.size(), 17);
      if (rx_q.size() == 17) begin
        for (int i = 0; i < W; i++) got[W-1-i] = rx_q[i];
        check("vec_word", got, vecs[v].word);
        check("vec_parity", rx_q[16], vecs[v].par);
      end
      check("vec_wordstarts", ws_cnt - w0, 1);
      check("vec_underruns", ur_cnt - u0, 1);
      bad = 0;
      for (int i = 1; i < stb_cyc_q.size(); i++)
        if (stb_cyc_q[i] - stb_cyc_q[i-1] != 16) bad++;
      check("vec_spacing", bad, 0);
      check("vec_line_idle", oSerData, 1'b0);
      check("vec_not_busy", oBusy, 1'b0);
    end

    // Back-to-back words, second accepted mid-word: no gap between frames
    stb_cyc_q.delete();
    s0 = stb_cnt;
    w0 = ws_cnt;
    u0 = ur_cnt;
    send_word(16'hFFFF);
    send_word(16'h0001);
    wait_underrun(1200);
    check("b2b_bits", stb_cnt - s0, 34);
    check("b2b_wordstarts", ws_cnt - w0, 2);
    check("b2b_underruns", ur_cnt - u0, 1);
    bad = 0;
    for (int i = 1; i < stb_cyc_q.size(); i++)
      if (stb_cyc_q[i] - stb_cyc_q[i-1] != 16) bad++;
    check("b2b_spacing", bad, 0);

    // Buffer full: a held handshake is ignored, oReady returns on the load
    send_word(16'h3C5A);
    send_word(16'hC0DE);
    iData  = 16'hBEEF;
    iValid = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (oReady !== 1'b0) bad++;
    end
    check("hold_ready_low", bad, 0);
    iValid   = 1'b0;
    found    = 1'b0;
    prev_rdy = oReady;
    n = 0;
    while (!found && n < 400) begin
      prev_rdy = oReady;
      step();
      n++;
      if (oWordStart) found = 1'b1;
    end
    check("hold_second_load", found, 1'b1);
    check("load_ready_before", prev_rdy, 1'b0);
    check("load_ready_after", oReady, 1'b1);
    wait_underrun(600);
    check("hold_no_extra", exp_q.size(), 0);

    // Word accepted on a tick cycle while idle: sent one period later
    n = 0;
    while (div_cnt != 7 && n < 40) begin
      step();
      n++;
    end
    iData  = 16'h5A0F;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    push_word(16'h5A0F);
    $display("tx word %h accepted on tick at cycle %0d", 16'h5A0F, cyc);
    check("tick_accept_taken", oReady, 1'b0);
    check("tick_accept_no_bit", oBitStb, 1'b0);
    n = 0;
    while (!oBitStb && n < 40) begin
      step();
      n++;
    end
    check("tick_accept_latency", n, 16);
    check("tick_accept_ws", oWordStart, 1'b1);
    wait_underrun(600);

    // Reset after the 5th bit of 16'h1234, with another word buffered
    s0 = stb_cnt;
    send_word(16'h1234);
    send_word(16'h5678);
    n = 0;
    while (stb_cnt - s0 < 5 && n < 400) begin
      step();
      n++;
    end
    check("midword_reached", stb_cnt - s0, 5);
    reset = 1'b0;
    #1;
    check("mid_rst_ser", oSerData, 1'b0);
    check("mid_rst_ready", oReady, 1'b1);
    check("mid_rst_stb", oBitStb, 1'b0);
    check("mid_rst_ws", oWordStart, 1'b0);
    check("mid_rst_busy", oBusy, 1'b0);
    check("mid_rst_underrun", oUnderrun, 1'b0);
    exp_q.delete();
    $display("reset asserted mid-word at cycle %0d", cyc);
    repeat (3) step();
    reset = 1'b1;
    s0 = stb_cnt;
    u0 = ur_cnt;
    repeat (100) step();
    check("post_reset_silent", stb_cnt - s0, 0);
    check("post_reset_no_ur", ur_cnt - u0, 0);
    check("post_reset_busy", oBusy, 1'b0);

    // Divided clock high when reset releases: first bit only after fall+rise
    div_en  = 1'b0;
    iDivClk = 1'b1;
    reset   = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    send_word(16'h00F0);
    s0 = stb_cnt;
    repeat (10) step();
    check("held_high_no_tick", stb_cnt - s0, 0);
    iDivClk = 1'b0;
    repeat (2) step();
    iDivClk = 1'b1;
    step();
    check("rise_after_fall_stb", oBitStb, 1'b1);
    check("rise_after_fall_ws", oWordStart, 1'b1);
    div_cnt = 8;
    div_en  = 1'b1;
    wait_underrun(600);

    // Randomized words and gaps against the bit-queue model
    for (int r = 0; r < 12; r++) begin
      rw = W'($urandom);
      repeat ($urandom_range(0, 300)) step();
      send_word(rw);
    end
    n = 0;
    while ((exp_q.size() != 0 || oBusy) && n < 2000) begin
      step();
      n++;
    end
    check("rand_drained", exp_q.size(), 0);
    check("rand_not_busy", oBusy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
